// File: rtl/aes_pkg.sv
// Shared AES definitions for the AddRoundKey engine and its key file.
// Width defaults, round-count constants and the default-width stage payload.
package aes_pkg;

   localparam int DATA_W_DEF   = 128;
   localparam int IDX_W_DEF    = 4;
   localparam int NUM_KEYS_DEF = 15;

   localparam logic [IDX_W_DEF-1:0] AES_NR_128 = 4'd10;
   localparam logic [IDX_W_DEF-1:0] AES_NR_192 = 4'd12;
   localparam logic [IDX_W_DEF-1:0] AES_NR_256 = 4'd14;

   // Stage payload at the default widths; parametrised users declare the
   // same field layout at their own widths.
   typedef struct packed {
      logic                  valid;
      logic [DATA_W_DEF-1:0] state;
      logic [IDX_W_DEF-1:0]  round;
      logic                  err;
   } ark_stage_t;

endpackage

// File: rtl/ark_keyfile.sv
// Round-key register file with per-entry valid bits and a combinational
// lookup that maps (round, Nr, direction) to a key plus an error flag.
module ark_keyfile
   import aes_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_KEYS = NUM_KEYS_DEF,
   parameter int IDX_W    = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              key_we,
   input  logic [IDX_W-1:0]  key_idx,
   input  logic [DATA_W-1:0] key_data,
   input  logic              key_clr,
   input  logic [IDX_W-1:0]  rd_round,
   input  logic [IDX_W-1:0]  rd_nr,
   input  logic              rd_decrypt,
   output logic [DATA_W-1:0] rd_key,
   output logic              rd_err
);

   logic [DATA_W-1:0]   key_vec [NUM_KEYS];
   logic [NUM_KEYS-1:0] valid_vec;
   logic [IDX_W-1:0]    eff_idx;
   logic                hit_valid;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_entry
         logic [DATA_W-1:0] key_reg;
         logic              valid_reg;
         logic              wr_hit;

         // Out-of-range write indices never match an entry, so they are dropped.
         assign wr_hit = key_we && (key_idx == IDX_W'(gi));

         // Key storage carries no reset; the valid bit guards stale contents.
         always_ff @(posedge clk) begin
            if (wr_hit) begin
               key_reg <= key_data;
            end
         end

         // Valid bit: reset and clear take priority over a write.
         always_ff @(posedge clk) begin
            if (srst || key_clr) begin
               valid_reg <= 1'b0;
            end else if (wr_hit) begin
               valid_reg <= 1'b1;
            end
         end

         assign key_vec[gi]   = key_reg;
         assign valid_vec[gi] = valid_reg;
      end
   endgenerate

   // Decrypt walks the schedule backwards; wraps modulo 2^IDX_W.
   assign eff_idx = rd_decrypt ? (rd_nr - rd_round) : rd_round;

   // Lookup: an index past the file finds no entry and reads as unloaded.
   always_comb begin
      rd_key    = '0;
      hit_valid = 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (eff_idx == IDX_W'(i)) begin
            rd_key    = key_vec[i];
            hit_valid = valid_vec[i];
         end
      end
      rd_err = (rd_round > rd_nr) || !hit_valid;
   end

endmodule

// File: rtl/add_round_key_engine.sv
// Pipelined AddRoundKey stage: keys the incoming state in the accept cycle,
// then carries it through LATENCY registers under a single global stall.
module add_round_key_engine
   import aes_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_KEYS = NUM_KEYS_DEF,
   parameter int IDX_W    = IDX_W_DEF,
   parameter int LATENCY  = 1
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iKeyWe,
   input  logic [IDX_W-1:0]  iKeyIdx,
   input  logic [DATA_W-1:0] iKeyData,
   input  logic              iKeyClr,
   input  logic [IDX_W-1:0]  iNr,
   input  logic              iValid,
   output logic              oReady,
   input  logic [DATA_W-1:0] iState,
   input  logic [IDX_W-1:0]  iRound,
   input  logic              iDecrypt,
   output logic              oValid,
   input  logic              iReady,
   output logic [DATA_W-1:0] oState,
   output logic [IDX_W-1:0]  oRound,
   output logic              oErr
);

   // Same layout as aes_pkg::ark_stage_t, sized by this instance's parameters.
   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] state;
      logic [IDX_W-1:0]  round;
      logic              err;
   } stage_t;

   logic [DATA_W-1:0] key_sel;
   logic              key_err;
   logic              advance;
   stage_t            stage_in;
   stage_t            stage_reg [LATENCY];

   ark_keyfile #(
      .DATA_W   (DATA_W),
      .NUM_KEYS (NUM_KEYS),
      .IDX_W    (IDX_W)
   ) u_keyfile (
      .clk        (iClk),
      .srst       (iRst),
      .key_we     (iKeyWe),
      .key_idx    (iKeyIdx),
      .key_data   (iKeyData),
      .key_clr    (iKeyClr),
      .rd_round   (iRound),
      .rd_nr      (iNr),
      .rd_decrypt (iDecrypt),
      .rd_key     (key_sel),
      .rd_err     (key_err)
   );

   // The whole pipe moves together whenever the output slot can be vacated.
   assign advance = !stage_reg[LATENCY-1].valid || iReady;
   assign oReady  = advance;

   // Form the stage-0 payload; an error passes the state through unkeyed.
   always_comb begin
      stage_in       = '0;
      stage_in.valid = iValid;
      stage_in.state = key_err ? iState : (iState ^ key_sel);
      stage_in.round = iRound;
      stage_in.err   = key_err;
   end

   // Shift register of stages; everything holds while stalled.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_reg[i] <= '0;
         end
      end else if (advance) begin
         stage_reg[0] <= stage_in;
         for (int i = 1; i < LATENCY; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign oValid = stage_reg[LATENCY-1].valid;
   assign oState = stage_reg[LATENCY-1].state;
   assign oRound = stage_reg[LATENCY-1].round;
   assign oErr   = stage_reg[LATENCY-1].err;

endmodule

// File: doc/add_round_key_engine.md
# add_round_key_engine

Parametrised, pipelined AddRoundKey stage with an internal round-key register file and a valid/ready stream interface. It is the sequential successor to the combinational AddRoundKeys XOR. The key expansion logic writes round keys into it once, and the round controller then streams state words tagged with a round index. It sits between MixColumns/ShiftRows and the next round register. It supports encrypt and decrypt key ordering, variable round count (AES-128/192/256) and configurable pipeline depth.

## Interface
- DATA_W, 128, state/key width in bits (multiple of 8)
- NUM_KEYS, 15, round-key entries (covers Nr ≤ 14)
- IDX_W, 4, round/key index width (≥ clog2(NUM_KEYS))
- LATENCY, 1, pipeline register stages, 1..4
- iClk  in  1  clock; all logic on rising edge
- iRst  in  1  synchronous, active-high reset
- iKeyWe  in  1  write iKeyData into entry iKeyIdx
- iKeyIdx  in  IDX_W  key entry index
- iKeyData  in  DATA_W  round key
- iKeyClr  in  1  clear all key-valid bits
- iNr  in  IDX_W  number of rounds (10/12/14), sampled per transfer
- iValid  in  1  input state valid
- oReady  out  1  engine can accept input this cycle
- iState  in  DATA_W  state to be keyed
- iRound  in  IDX_W  round number 0..iNr
- iDecrypt  in  1  1 = inverse key order
- oValid  out  1  output valid
- iReady  in  1  downstream accepts output
- oState  out  DATA_W  iState ^ selected key (or pass-through on error)
- oRound  out  IDX_W  iRound carried through
- oErr  out  1  transfer had invalid index or unloaded key

## Operation
- Key file: NUM_KEYS × DATA_W registers, no reset. Per-entry valid bit, reset to 0. iKeyWe sets the entry's valid bit. iKeyClr clears all valid bits; iKeyClr wins over a simultaneous iKeyWe.
- iKeyWe with iKeyIdx ≥ NUM_KEYS is ignored.
- Effective index: eff = iDecrypt ? (iNr − iRound) : iRound, computed in IDX_W bits.
- Error when iRound > iNr, eff ≥ NUM_KEYS, or valid[eff] = 0. On error, oState = iState unmodified and oErr = 1. Otherwise oState = iState ^ key[eff] and oErr = 0.
- Key lookup happens in the accept cycle. A key write to the same index in that cycle is not seen: the old value and old valid bit apply.
- Input transfer occurs on iValid & oReady. Output transfer occurs on oValid & iReady.
- Pipeline uses a global stall: advance = !oValid | iReady; oReady = advance. Stages hold their contents while stalled, and oState/oRound/oErr stay stable while oValid & !iReady.
- Bubbles (no input transfer) propagate as invalid stages. There is no reordering and no data loss.

## Timing
- Reset values: oValid 0, oState 0, oRound 0, oErr 0, all stage valids 0, all key-valid bits 0. oReady = 1 from the first cycle after reset.
- Latency: input accepted at edge N appears with oValid = 1 after edge N+LATENCY−1 (LATENCY=1 means registered output visible the cycle after accept).
- Throughput: one transfer per cycle while iReady = 1.
- A reset asserted mid-stream flushes all in-flight data (oValid = 0 next cycle) and invalidates all keys.
- Simultaneous input accept and output drain in the same cycle is required to work at full rate with no bubble.

## Structure
- Shared package aes_pkg holds DATA_W/IDX_W defaults, AES_NR_128/192/256 constants (10/12/14), and the stage payload struct {valid, state, round, err}.
- One sub-module, ark_keyfile: register file plus valid bits, clear, and combinational read with error decode. The pipeline and handshake stay in the top module.

## Test plan
- Load key 1 = d6aa74fdd2af72fadaa678f1d6ab76fe; send iState = 00112233445566778899aabbccddeeff, iRound = 1, iNr = 10, iDecrypt = 0 -> oState = d6bb56ce96fa148d523fd24a1a769801, oRound = 1, oErr = 0, after LATENCY cycles.
- Same key and state with iDecrypt = 1, iNr = 10, iRound = 9 -> the identical oState; with iRound = 11 -> oState = 00112233…eeff pass-through, oErr = 1.
- After reset with no keys loaded, send iRound = 0 -> pass-through, oErr = 1. Write key 0 and iKeyClr in the same cycle, then send round 0 -> oErr = 1.
- Stream 16 back-to-back inputs while holding iReady low for cycles 3–6 -> oReady low exactly while the pipe is full and stalled, output held stable, all 16 results delivered in order, no duplicates.
- In the same cycle, write key 2 = all-ones and accept an input using round 2 (old key all-zeros) -> oState = iState. The next input using round 2 -> oState = ~iState.
- Apply iRst with 3 transfers in flight -> oValid = 0 the next cycle, none of the 3 emerge afterwards. Repeat the first directed test for LATENCY = 1 and LATENCY = 4.
